// File: rtl/digital_capture_controller.sv
// Capture sequencer: arms, fills a pre-trigger window, waits for a qualified
// trigger, then fills a post-trigger window in a circular sample buffer.
module digital_capture_controller #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [ADDR_WIDTH:0]   pre_count,
    input  logic [ADDR_WIDTH:0]   post_count,
    input  logic                  sample_valid,
    input  logic                  trigger,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH-1:0] trig_addr,
    output logic [ADDR_WIDTH-1:0] start_addr,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_WAIT = 3'd2,
        S_POST = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t cur_state, nxt_state;

    logic [ADDR_WIDTH:0] pre_len, post_len;
    logic [ADDR_WIDTH:0] pre_cnt, post_cnt;
    logic [ADDR_WIDTH:0] post_clamp, pre_clamp, room;
    logic                arm_ok, trig_hit, pre_last, post_last;

    // Window lengths as they would be latched by an arm this cycle.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        post_clamp = (post_count == '0) ? ONE : post_count;
        if (post_clamp > DEPTH) post_clamp = DEPTH;
        room      = DEPTH - post_clamp;
        pre_clamp = (pre_count > room) ? room : pre_count;
    end

    assign arm_ok    = arm && !abort && (cur_state == S_IDLE || cur_state == S_DONE);
    assign trig_hit  = sample_valid && trigger && (cur_state == S_WAIT);
    assign pre_last  = wr_en && (cur_state == S_PRE)  && (pre_cnt + ONE == pre_len);
    assign post_last = wr_en && (cur_state == S_POST) && (post_cnt + ONE == post_len);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur_state <= S_IDLE;
        else        cur_state <= nxt_state;
    end

    always_comb begin
        nxt_state = cur_state;
        if (abort) begin
            nxt_state = S_IDLE;
        end else begin
            case (cur_state)
                S_IDLE, S_DONE: if (arm) nxt_state = (pre_clamp != '0) ? S_PRE : S_WAIT;
                S_PRE:          if (pre_last) nxt_state = S_WAIT;
                S_WAIT:         if (trig_hit) nxt_state = (post_len == ONE) ? S_DONE : S_POST;
                S_POST:         if (post_last) nxt_state = S_DONE;
                default:        nxt_state = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy  = (cur_state == S_PRE) || (cur_state == S_WAIT) || (cur_state == S_POST);
        done  = (cur_state == S_DONE);
        wr_en = sample_valid && busy;
        state = cur_state;
    end

    // Abort freezes the datapath so the last trigger/start addresses stay readable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr    <= '0;
            trig_addr  <= '0;
            start_addr <= '0;
            pre_cnt    <= '0;
            post_cnt   <= '0;
            pre_len    <= '0;
            post_len   <= '0;
        end else if (!abort) begin
            if (arm_ok) begin
                pre_len  <= pre_clamp;
                post_len <= post_clamp;
                pre_cnt  <= '0;
                post_cnt <= '0;
                wr_addr  <= '0;
            end else if (wr_en) begin
                wr_addr <= wr_addr + 1'b1;
                case (cur_state)
                    S_PRE:  pre_cnt <= pre_cnt + ONE;
                    S_WAIT: if (trigger) begin
                        trig_addr  <= wr_addr;
                        start_addr <= wr_addr - pre_len[ADDR_WIDTH-1:0];
                        post_cnt   <= ONE;
                    end
                    S_POST: post_cnt <= post_cnt + ONE;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_digital_capture_controller.sv
// Scoreboard bench: each capture's expected write addresses and trigger/start
// addresses come from a sample-index model; a negedge monitor pops and compares.
module tb_digital_capture_controller;

    localparam int AW = 4;
    localparam int D  = 16;

    logic          clk, rst_n, arm, abort, sample_valid, trigger;
    logic [AW:0]   pre_count, post_count;
    logic          wr_en, busy, done;
    logic [AW-1:0] wr_addr, trig_addr, start_addr;
    logic [2:0]    state;

    digital_capture_controller #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort),
        .pre_count(pre_count), .post_count(post_count),
        .sample_valid(sample_valid), .trigger(trigger),
        .wr_en(wr_en), .wr_addr(wr_addr), .trig_addr(trig_addr),
        .start_addr(start_addr), .busy(busy), .done(done), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int wr_total = 0;
    bit saw_post = 0;
    logic [AW-1:0]   exp_addr[$];
    logic [2*AW-1:0] exp_res[$];
    logic            done_prev = 1'b0;
    logic [AW-1:0]   mon_a;
    logic [2*AW-1:0] mon_r;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write and every completed capture is checked against the queues.
    always @(negedge clk) begin
        if (wr_en) begin
            wr_total++;
            if (exp_addr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got wr_addr=%0d expected no write at %0t", wr_addr, $time);
            end else begin
                mon_a = exp_addr.pop_front();
                check("wr_addr", wr_addr, mon_a);
            end
        end
        if (state == 3'd3) saw_post = 1;
        if (done && !done_prev) begin
            if (exp_res.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no capture at %0t", $time);
            end else begin
                mon_r = exp_res.pop_front();
                check("trig_addr", trig_addr, mon_r[2*AW-1:AW]);
                check("start_addr", start_addr, mon_r[AW-1:0]);
                check("writes_left_at_done", exp_addr.size(), 0);
            end
        end
        done_prev = done;
    end

    task automatic drive(bit v, bit t);
        sample_valid = v;
        trigger      = t;
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm(int pre, int post);
        pre_count    = (AW+1)'(pre);
        post_count   = (AW+1)'(post);
        arm          = 1'b1;
        sample_valid = 1'b0;
        @(posedge clk);
        #1;
        arm        = 1'b0;
        pre_count  = (AW+1)'($urandom);
        post_count = (AW+1)'($urandom);
    endtask

    // Model: the i-th valid sample after arm lands at address i mod D; the
    // trigger is the first sample at index >= pre_len with trigger set.
    task automatic capture(int pre, int post, int off, int gap_mode, bit early_ones, int n_drive);
        int post_len, pre_len, k, total, lim, ng;
        bit trig_bits[$];
        post_len = (post == 0) ? 1 : post;
        if (post_len > D) post_len = D;
        pre_len = (pre > D - post_len) ? D - post_len : pre;
        for (int i = 0; i < pre_len + off + post_len + 3; i++) begin
            if (i < pre_len)            trig_bits.push_back(early_ones ? 1'b1 : 1'($urandom_range(0, 1)));
            else if (i < pre_len + off) trig_bits.push_back(1'b0);
            else if (i == pre_len + off) trig_bits.push_back(1'b1);
            else                        trig_bits.push_back(1'($urandom_range(0, 1)));
        end
        k = pre_len;
        while (!trig_bits[k]) k++;
        total = k + post_len;
        for (int i = 0; i < total; i++) exp_addr.push_back(AW'(i % D));
        exp_res.push_back({AW'(k % D), AW'((k - pre_len) % D)});
        do_arm(pre, post);
        lim = (n_drive > 0) ? n_drive : trig_bits.size();
        for (int i = 0; i < lim; i++) begin
            ng = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : $urandom_range(0, 2);
            repeat (ng) drive(1'b0, 1'($urandom_range(0, 1)));
            drive(1'b1, trig_bits[i]);
        end
        sample_valid = 1'b0;
        trigger      = 1'b0;
        if (n_drive == 0) begin
            check("done_at_end", done, 1);
            check("state_at_end", state, 4);
            check("busy_at_end", busy, 0);
        end
    endtask

    task automatic check_reset_values(string tag);
        check({tag, "_state"}, state, 0);
        check({tag, "_wr_addr"}, wr_addr, 0);
        check({tag, "_trig_addr"}, trig_addr, 0);
        check({tag, "_start_addr"}, start_addr, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_wr_en"}, wr_en, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int wb;
        rst_n = 1'b0; arm = 1'b0; abort = 1'b0;
        sample_valid = 1'b0; trigger = 1'b0;
        pre_count = '0; post_count = '0;
        #12;
        check_reset_values("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Basic capture: trigger on the 7th sample.
        wb = wr_total;
        capture(4, 4, 2, 0, 0, 0);
        check("basic_trig_addr", trig_addr, 6);
        check("basic_start_addr", start_addr, 2);
        check("basic_write_count", wr_total - wb, 10);

        // Wrap: trigger after 20 valid samples.
        capture(8, 8, 12, 0, 0, 0);
        check("wrap_trig_addr", trig_addr, 4);
        check("wrap_start_addr", start_addr, 12);
        check("wrap_wr_addr_after", wr_addr, 12);

        // Clamp: post_len=1, pre_len=15, no POST state.
        saw_post = 0;
        capture(16, 0, 2, 0, 0, 0);
        check("clamp_no_post", saw_post, 0);
        check("clamp_trig_addr", trig_addr, 1);
        check("clamp_start_addr", start_addr, 2);

        // Early trigger held through PRE.
        capture(3, 5, 0, 0, 1, 0);
        check("early_trig_addr", trig_addr, 3);

        // Alternating sample_valid gaps.
        capture(5, 6, 4, 1, 0, 0);

        // Abort and arm together during POST.
        capture(2, 8, 1, 0, 0, 6);
        check("pre_abort_state", state, 3);
        check("pre_abort_busy", busy, 1);
        exp_addr.delete();
        exp_res.delete();
        sample_valid = 1'b0;
        abort = 1'b1; arm = 1'b1; pre_count = '0; post_count = 5'd1;
        @(posedge clk); #1;
        abort = 1'b0; arm = 1'b0;
        check("abort_state", state, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_trig_hold", trig_addr, 3);
        check("abort_start_hold", start_addr, 1);
        repeat (5) drive(1'b1, 1'b1);
        sample_valid = 1'b0; trigger = 1'b0;
        check("abort_stays_idle", state, 0);
        capture(1, 2, 3, 0, 0, 0);

        // Asynchronous reset in the middle of POST.
        capture(3, 10, 2, 0, 0, 8);
        check("pre_reset_state", state, 3);
        sample_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        exp_addr.delete();
        exp_res.delete();
        sample_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        capture(2, 3, 1, 2, 0, 0);

        // Randomized captures.
        for (int n = 0; n < 25; n++)
            capture($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 20),
                    $urandom_range(0, 2), 0, 0);

        repeat (3) @(posedge clk);
        #1;
        check("final_addr_queue_empty", exp_addr.size(), 0);
        check("final_result_queue_empty", exp_res.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
